// File: rtl/mulacc_l2_cfu_if.sv
// Request/response bundle of the multiply-accumulate CFU.
// resp_status codes: 0 OK, 1 ERROR_FUNC, 2 ERROR_STATE, 3 ERROR_OFF.
interface mulacc_l2_cfu_if #(
  parameter int FUNC_W  = 10,
  parameter int STATE_W = 2,
  parameter int DATA_W  = 32
);
  logic               req_valid;
  logic               req_ready;
  logic [FUNC_W-1:0]  req_func;
  logic [STATE_W-1:0] req_state;
  logic [DATA_W-1:0]  req_data0;
  logic [DATA_W-1:0]  req_data1;
  logic               resp_valid;
  logic               resp_ready;
  logic [1:0]         resp_status;
  logic [DATA_W-1:0]  resp_data;

  modport master (
    output req_valid, req_func, req_state, req_data0, req_data1, resp_ready,
    input  req_ready, resp_valid, resp_status, resp_data
  );

  modport slave (
    input  req_valid, req_func, req_state, req_data0, req_data1, resp_ready,
    output req_ready, resp_valid, resp_status, resp_data
  );
endinterface

// File: rtl/mulacc_l2_cfu.sv
// Multi-context multiply-accumulate CFU with an iterative shift-add multiplier
// retiring BITS_PER_CYCLE multiplier bits per clock.
module mulacc_l2_cfu #(
  parameter int CFU_N_STATES   = 4,
  parameter int CFU_FUNC_ID_W  = 10,
  parameter int CFU_DATA_W     = 32,
  parameter int BITS_PER_CYCLE = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           clk_en,
  mulacc_l2_cfu_if.slave cfu
);
  localparam int DW    = CFU_DATA_W;
  localparam int BPC   = BITS_PER_CYCLE;
  localparam int K     = DW / BPC;
  localparam int CNT_W = (K > 1) ? $clog2(K) : 1;
  localparam int IDX_W = (CFU_N_STATES > 1) ? $clog2(CFU_N_STATES) : 1;
  localparam logic [IDX_W:0] N_LIM = (IDX_W + 1)'(CFU_N_STATES);

  localparam logic [CFU_FUNC_ID_W-1:0] F_MUL          = CFU_FUNC_ID_W'(0);
  localparam logic [CFU_FUNC_ID_W-1:0] F_MULACC       = CFU_FUNC_ID_W'(1);
  localparam logic [CFU_FUNC_ID_W-1:0] F_MULSUB       = CFU_FUNC_ID_W'(2);
  localparam logic [CFU_FUNC_ID_W-1:0] F_WRITE_STATE  = CFU_FUNC_ID_W'(1020);
  localparam logic [CFU_FUNC_ID_W-1:0] F_READ_STATE   = CFU_FUNC_ID_W'(1021);
  localparam logic [CFU_FUNC_ID_W-1:0] F_WRITE_STATUS = CFU_FUNC_ID_W'(1022);
  localparam logic [CFU_FUNC_ID_W-1:0] F_READ_STATUS  = CFU_FUNC_ID_W'(1023);

  localparam logic [1:0] CS_OFF = 2'd0, CS_INIT = 2'd1, CS_DIRTY = 2'd3;
  localparam logic [1:0] STS_OK = 2'd0, STS_FUNC = 2'd1, STS_STATE = 2'd2, STS_OFF = 2'd3;

  typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_RESP} state_e;

  // CSW layout: cs in [1:0], state_size (always 1 word) in [31:22].
  function automatic logic [DW-1:0] make_csw(input logic [1:0] cs);
    logic [DW-1:0] w;
    w        = '0;
    w[1:0]   = cs;
    w[31:22] = 10'd1;
    return w;
  endfunction

  state_e                   state_q, state_d;
  logic [CFU_FUNC_ID_W-1:0] func_q, func_d;
  logic [IDX_W-1:0]         idx_q, idx_d;
  logic [DW-1:0]            mcand_q, mcand_d;
  logic [DW-1:0]            mplier_q, mplier_d;
  logic [DW-1:0]            prod_q, prod_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [1:0]               resp_status_q, resp_status_d;
  logic [DW-1:0]            resp_data_q, resp_data_d;
  logic                     ready_q, ready_d;
  logic [1:0]               cs_q [CFU_N_STATES];
  logic [1:0]               cs_d [CFU_N_STATES];
  logic [CFU_N_STATES-1:0]  zf_q, zf_d;

  // Accumulator storage is never reset; the zero flags mask stale contents.
  logic [DW-1:0]            acc_mem [CFU_N_STATES];
  logic                     acc_we;
  logic [IDX_W-1:0]         acc_widx;
  logic [DW-1:0]            acc_wdata;

  logic                     req_ready_int, accept, state_ok, req_is_mul, req_known;
  logic [1:0]               req_cs, req_err;
  logic [DW-1:0]            req_acc, mul_acc, new_acc, pp_sum;
  logic [DW-1:0]            pp_term [BPC];

  for (genvar gi = 0; gi < BPC; gi++) begin : g_pp
    assign pp_term[gi] = mplier_q[gi] ? (mcand_q << gi) : '0;
  end

  always_comb begin
    pp_sum = '0;
    for (int i = 0; i < BPC; i++) pp_sum = pp_sum + pp_term[i];
  end

  assign req_ready_int = ready_q && (state_q == ST_IDLE);
  assign accept        = cfu.req_valid && req_ready_int && clk_en;
  assign state_ok      = {1'b0, cfu.req_state} < N_LIM;
  assign req_cs        = state_ok ? cs_q[cfu.req_state] : CS_OFF;
  assign req_acc       = zf_q[cfu.req_state] ? '0 : acc_mem[cfu.req_state];
  assign mul_acc       = zf_q[idx_q] ? '0 : acc_mem[idx_q];
  assign req_is_mul    = (cfu.req_func == F_MUL) || (cfu.req_func == F_MULACC) ||
                         (cfu.req_func == F_MULSUB);
  assign req_known     = req_is_mul || (cfu.req_func == F_WRITE_STATE) ||
                         (cfu.req_func == F_READ_STATE) || (cfu.req_func == F_WRITE_STATUS) ||
                         (cfu.req_func == F_READ_STATUS);

  always_comb begin
    req_err = STS_OK;
    if (!state_ok)
      req_err = STS_STATE;
    else if (req_cs == CS_OFF && cfu.req_func != F_WRITE_STATUS && cfu.req_func != F_READ_STATUS)
      req_err = STS_OFF;
    else if (!req_known)
      req_err = STS_FUNC;
  end

  always_comb begin
    state_d       = state_q;
    func_d        = func_q;
    idx_d         = idx_q;
    mcand_d       = mcand_q;
    mplier_d      = mplier_q;
    prod_d        = prod_q;
    cnt_d         = cnt_q;
    resp_status_d = resp_status_q;
    resp_data_d   = resp_data_q;
    ready_d       = ready_q;
    cs_d          = cs_q;
    zf_d          = zf_q;
    acc_we        = 1'b0;
    acc_widx      = idx_q;
    acc_wdata     = prod_q;
    new_acc       = '0;
    if (clk_en) begin
      ready_d = 1'b1;
      unique case (state_q)
        ST_IDLE: begin
          if (accept) begin
            func_d = cfu.req_func;
            idx_d  = cfu.req_state;
            if (req_err == STS_OK && req_is_mul) begin
              state_d  = ST_MUL;
              mcand_d  = cfu.req_data0;
              mplier_d = cfu.req_data1;
              prod_d   = '0;
              cnt_d    = '0;
            end else begin
              // Single-cycle functions commit on the accept edge itself.
              state_d       = ST_RESP;
              resp_status_d = req_err;
              resp_data_d   = '0;
              if (req_err == STS_OK) begin
                case (cfu.req_func)
                  F_WRITE_STATE: begin
                    acc_we                 = 1'b1;
                    acc_widx               = cfu.req_state;
                    acc_wdata              = cfu.req_data0;
                    zf_d[cfu.req_state]    = 1'b0;
                    cs_d[cfu.req_state]    = CS_DIRTY;
                    resp_data_d            = cfu.req_data0;
                  end
                  F_READ_STATE: resp_data_d = req_acc;
                  F_WRITE_STATUS: begin
                    resp_data_d         = make_csw(req_cs);
                    cs_d[cfu.req_state] = cfu.req_data0[1:0];
                    if (cfu.req_data0[1:0] == CS_OFF || cfu.req_data0[1:0] == CS_INIT)
                      zf_d[cfu.req_state] = 1'b1;
                  end
                  default: resp_data_d = make_csw(req_cs);
                endcase
              end
            end
          end
        end
        ST_MUL: begin
          prod_d   = prod_q + pp_sum;
          mcand_d  = mcand_q << BPC;
          mplier_d = mplier_q >> BPC;
          cnt_d    = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(K - 1)) begin
            if (func_q == F_MUL)         new_acc = prod_d;
            else if (func_q == F_MULACC) new_acc = mul_acc + prod_d;
            else                         new_acc = mul_acc - prod_d;
            acc_we        = 1'b1;
            acc_widx      = idx_q;
            acc_wdata     = new_acc;
            zf_d[idx_q]   = 1'b0;
            cs_d[idx_q]   = CS_DIRTY;
            resp_status_d = STS_OK;
            resp_data_d   = new_acc;
            state_d       = ST_RESP;
          end
        end
        ST_RESP: begin
          if (cfu.resp_ready) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      func_q        <= '0;
      idx_q         <= '0;
      mcand_q       <= '0;
      mplier_q      <= '0;
      prod_q        <= '0;
      cnt_q         <= '0;
      resp_status_q <= STS_OK;
      resp_data_q   <= '0;
      ready_q       <= 1'b0;
      zf_q          <= '1;
      for (int i = 0; i < CFU_N_STATES; i++) cs_q[i] <= CS_INIT;
    end else begin
      state_q       <= state_d;
      func_q        <= func_d;
      idx_q         <= idx_d;
      mcand_q       <= mcand_d;
      mplier_q      <= mplier_d;
      prod_q        <= prod_d;
      cnt_q         <= cnt_d;
      resp_status_q <= resp_status_d;
      resp_data_q   <= resp_data_d;
      ready_q       <= ready_d;
      zf_q          <= zf_d;
      cs_q          <= cs_d;
    end
  end

  always_ff @(posedge clk) begin
    if (acc_we) acc_mem[acc_widx] <= acc_wdata;
  end

  assign cfu.req_ready   = req_ready_int;
  assign cfu.resp_valid  = (state_q == ST_RESP);
  assign cfu.resp_status = resp_status_q;
  assign cfu.resp_data   = resp_data_q;
endmodule
